// File: rtl/grid_pkg.sv
// Shared constants for the grid piece mover: button bit positions and
// the per-button debouncer state encoding.
package grid_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHECK   = 2'd1,
        IDLE_HI = 2'd2
    } deb_state_t;

endpackage

// File: rtl/grid_piece_mover_btn_debounce.sv
// One pushbutton channel: 2-flop synchroniser, debouncer that accepts a new
// level after DEB_CYCLES consecutive equal samples, and a one-cycle pulse on
// each accepted rising level.
module btn_debounce
    import grid_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    sync;
    logic          s;
    deb_state_t    state, state_n;
    logic [DW-1:0] cnt, cnt_n;
    logic          lvl, lvl_n;
    logic          rise_n;

    assign s = sync[1];

    // Synchroniser and debouncer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            state <= IDLE_LO;
            cnt   <= '0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_n;
            cnt   <= cnt_n;
            lvl   <= lvl_n;
            rise  <= rise_n;
        end
    end

    // Count consecutive samples that differ from the accepted level
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lvl_n   = lvl;
        rise_n  = 1'b0;
        case (state)
            IDLE_LO, IDLE_HI: begin
                if (s != lvl) begin
                    if (DEB_CYCLES == 1) begin
                        lvl_n   = s;
                        rise_n  = s;
                        state_n = s ? IDLE_HI : IDLE_LO;
                        cnt_n   = '0;
                    end else begin
                        state_n = CHECK;
                        cnt_n   = DW'(1);
                    end
                end
            end
            CHECK: begin
                if (s == lvl) begin
                    state_n = lvl ? IDLE_HI : IDLE_LO;
                    cnt_n   = '0;
                end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                    lvl_n   = s;
                    rise_n  = s;
                    state_n = s ? IDLE_HI : IDLE_LO;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + DW'(1);
                end
            end
            default: begin
                state_n = IDLE_LO;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/grid_piece_mover.sv
// Moves a single piece around a ROWS x COLS grid from four debounced
// pushbuttons. Optional gravity (macro GRID_GRAVITY_EN) drops the piece one
// row per DROP_DIV cycles and respawns it after it lands on row 0.
module grid_piece_mover
    import grid_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int ROWS       = 3,
    parameter int SPAWN_COL  = 0,
    parameter int DEB_CYCLES = 500000,
    parameter int DROP_DIV   = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               button,
    output logic [ROWS*COLS-1:0]     cells,
    output logic [$clog2(ROWS)-1:0]  row_pos,
    output logic [$clog2(COLS)-1:0]  col_pos,
    output logic                     bump,
    output logic                     landed
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    function automatic logic [ROWS*COLS-1:0] cell_image(input logic [RW-1:0] r,
                                                        input logic [CW-1:0] c);
        logic [ROWS*COLS-1:0] img;
        img = '0;
        img[int'(r) * COLS + int'(c)] = 1'b1;
        return img;
    endfunction

    logic [3:0]    req;
    logic          single_req;
    logic          tick;
    logic [RW-1:0] row_n;
    logic [CW-1:0] col_n;
    logic          bump_n, landed_n;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (button[i]),
            .rise (req[i])
        );
    end

    // Simultaneous requests on several buttons are treated as ambiguous
    assign single_req = (req != 4'b0000) && ((req & (req - 4'b0001)) == 4'b0000);

`ifdef GRID_GRAVITY_EN
    localparam int GW = $clog2(DROP_DIV);
    logic [GW-1:0] grav_cnt;

    assign tick = (grav_cnt == GW'(DROP_DIV - 1));

    // Free-running gravity divider, wraps on the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grav_cnt <= '0;
        end else if (tick) begin
            grav_cnt <= '0;
        end else begin
            grav_cnt <= grav_cnt + GW'(1);
        end
    end
`else
    assign tick = 1'b0;
`endif

    // Next position: gravity has priority over any button request
    always_comb begin
        row_n    = row_pos;
        col_n    = col_pos;
        bump_n   = 1'b0;
        landed_n = 1'b0;
        if (tick) begin
            if (row_pos != '0) begin
                row_n = row_pos - RW'(1);
            end else begin
                landed_n = 1'b1;
                row_n    = RW'(ROWS - 1);
                col_n    = CW'(SPAWN_COL);
            end
        end else if (single_req) begin
            if (req[BTN_LEFT]) begin
                if (col_pos == '0) bump_n = 1'b1;
                else               col_n  = col_pos - CW'(1);
            end else if (req[BTN_RIGHT]) begin
                if (col_pos == CW'(COLS - 1)) bump_n = 1'b1;
                else                          col_n  = col_pos + CW'(1);
            end else if (req[BTN_DOWN]) begin
                if (row_pos == '0) bump_n = 1'b1;
                else               row_n  = row_pos - RW'(1);
            end else begin
                if (row_pos == RW'(ROWS - 1)) bump_n = 1'b1;
                else                          row_n  = row_pos + RW'(1);
            end
        end
    end

    // Position, cell image and event pulses are registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_pos <= RW'(ROWS - 1);
            col_pos <= CW'(SPAWN_COL);
            cells   <= cell_image(RW'(ROWS - 1), CW'(SPAWN_COL));
            bump    <= 1'b0;
            landed  <= 1'b0;
        end else begin
            row_pos <= row_n;
            col_pos <= col_n;
            cells   <= cell_image(row_n, col_n);
            bump    <= bump_n;
            landed  <= landed_n;
        end
    end

endmodule

// File: tb/tb_grid_piece_mover.sv
// Scoreboard bench for grid_piece_mover: a reference model predicts every
// cycle's outputs from the raw button history; a monitor compares them.
module tb_grid_piece_mover;

    localparam int COLS = 4, ROWS = 3, SPAWN_COL = 0, DEB = 4, DROP = 64;
`ifdef GRID_GRAVITY_EN
    localparam bit GRAV = 1'b1;
`else
    localparam bit GRAV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  button = 4'b0000;
    logic [11:0] cells;
    logic [1:0]  row_pos, col_pos;
    logic        bump, landed;

    grid_piece_mover #(
        .COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL),
        .DEB_CYCLES(DEB), .DROP_DIV(DROP)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .cells(cells),
        .row_pos(row_pos), .col_pos(col_pos), .bump(bump), .landed(landed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]  row;
        logic [1:0]  col;
        logic [11:0] cells;
        logic        bump;
        logic        landed;
    } exp_t;

    exp_t sbq[$];

    // ---------------- reference model ----------------
    logic [3:0] hist[$];     // raw button value sampled at edge j is hist[j-1]
    int         k;           // edges since reset release
    bit         level[4];
    logic [3:0] pend;        // requests to act on at the next edge
    int         mrow, mcol;

    function automatic bit raw_at(input int j, input int b);
        if (j < 1) return 1'b0;
        return hist[j-1][b];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            sbq.delete();
            k = 0;
            pend = 4'b0000;
            mrow = ROWS - 1;
            mcol = SPAWN_COL;
            for (int b = 0; b < 4; b++) level[b] = 1'b0;
        end else begin
            exp_t       e;
            logic [3:0] act, nreq;
            bit         tk, bmp, lnd;
            k++;
            hist.push_back(button);
            act  = pend;
            nreq = 4'b0000;
            // A level is accepted once the last DEB synchronised samples
            // (raw samples two edges old) all agree and differ from it.
            for (int b = 0; b < 4; b++) begin
                bit v, same;
                v = raw_at(k - 2, b);
                same = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (raw_at(k - 2 - i, b) != v) same = 1'b0;
                if (same && v != level[b]) begin
                    level[b] = v;
                    if (v) nreq[b] = 1'b1;
                end
            end
            tk  = GRAV && (k % DROP == 0);
            bmp = 1'b0;
            lnd = 1'b0;
            if (tk) begin
                if (mrow > 0) mrow--;
                else begin
                    lnd = 1'b1;
                    mrow = ROWS - 1;
                    mcol = SPAWN_COL;
                end
            end else if ($countones(act) == 1) begin
                if (act[0])      begin if (mcol == 0)        bmp = 1'b1; else mcol--; end
                else if (act[3]) begin if (mcol == COLS - 1) bmp = 1'b1; else mcol++; end
                else if (act[1]) begin if (mrow == 0)        bmp = 1'b1; else mrow--; end
                else             begin if (mrow == ROWS - 1) bmp = 1'b1; else mrow++; end
            end
            pend     = nreq;
            e.row    = 2'(mrow);
            e.col    = 2'(mcol);
            e.cells  = 12'(1) << (mrow * COLS + mcol);
            e.bump   = bmp;
            e.landed = lnd;
            sbq.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("row_pos", 32'(row_pos), 32'(e.row));
                chk("col_pos", 32'(col_pos), 32'(e.col));
                chk("cells",   32'(cells),   32'(e.cells));
                chk("bump",    32'(bump),    32'(e.bump));
                chk("landed",  32'(landed),  32'(e.landed));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [3:0] b, input int n);
        button = b;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        chk("rst_row",    32'(row_pos), 32'(ROWS - 1));
        chk("rst_col",    32'(col_pos), 32'(SPAWN_COL));
        chk("rst_cells",  32'(cells),   32'h100);
        chk("rst_bump",   32'(bump),    32'd0);
        chk("rst_landed", 32'(landed),  32'd0);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        do_reset(3);
        // first move right, then walk into the right edge
        hold(4'b1000, 20); hold(4'b0000, 10);
        hold(4'b1000, 10); hold(4'b0000, 10);
        hold(4'b1000, 10); hold(4'b0000, 10);
        hold(4'b1000, 10); hold(4'b0000, 10);
        // row+1 from the top row
        do_reset(2);
        hold(4'b0100, 12); hold(4'b0000, 10);
        // short glitches, then a two-button press and release
        for (int i = 0; i < 5; i++) begin
            hold(4'b0001, 2); hold(4'b0000, 2);
        end
        hold(4'b0000, 10);
        hold(4'b1001, 12); hold(4'b0000, 12);
        // idle through three gravity ticks
        do_reset(2);
        hold(4'b0000, 200);
        // move request landing on the tick edge
        do_reset(2);
        hold(4'b0000, 57); hold(4'b1000, 12); hold(4'b0000, 10);
        // reset in the middle of a debounce
        hold(4'b1000, 3);
        button = 4'b0000;
        do_reset(2);
        hold(4'b0000, 20);
        // button held through reset release
        button = 4'b0010;
        do_reset(2);
        hold(4'b0010, 15); hold(4'b0000, 5);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [3:0] b;
            sel = $urandom_range(0, 9);
            if (sel < 7)      b = 4'(1 << $urandom_range(0, 3));
            else if (sel < 8) b = 4'b0000;
            else              b = 4'($urandom_range(0, 15));
            hold(b, $urandom_range(1, 12));
        end
        hold(4'b0000, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_piece_mover.md
GRID_PIECE_MOVER -- requirements
Module: grid_piece_mover

Interface
REQ-001 SHALL have parameter COLS, default 4, grid columns (>=2).
REQ-002 SHALL have parameter ROWS, default 3, grid rows (>=2).
REQ-003 SHALL have parameter SPAWN_COL, default 0, spawn column (<COLS).
REQ-004 SHALL have parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a button level (>=1).
REQ-005 SHALL have parameter DROP_DIV, default 50000000, clock cycles per gravity tick (>=2).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port button  input  4  raw asynchronous pushbuttons: [0] col-1, [3] col+1, [2] row+1, [1] row-1.
REQ-009 SHALL have port cells  output  ROWS*COLS  one-hot piece image; row r at bits [r*COLS +: COLS], bit r*COLS+c = cell (r,c).
REQ-010 SHALL have port row_pos  output  clog2(ROWS)  current row.
REQ-011 SHALL have port col_pos  output  clog2(COLS)  current column.
REQ-012 SHALL have port bump  output  1  one-cycle pulse when an accepted move is blocked by a grid edge.
REQ-013 SHALL have port landed  output  1  one-cycle pulse when gravity ticks with the piece on row 0.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DEB_CYCLES consecutive equal synchronised samples.
REQ-015 A move request SHALL be the rising edge of a debounced level; falling edges SHALL produce nothing.
REQ-016 A raw press held stable SHALL update row_pos/col_pos exactly DEB_CYCLES+3 rising edges after the first edge sampling it high.
REQ-017 Requests arriving in the same cycle on two or more buttons SHALL all be discarded, no bump.
REQ-018 A move off the grid (col 0 with col-1, col COLS-1 with col+1, row 0 with row-1, row ROWS-1 with row+1) SHALL leave position unchanged and pulse bump next cycle; no wrap-around between rows or columns.
REQ-019 Gravity counter SHALL count 0..DROP_DIV-1 and wrap; a tick SHALL occur on the wrap cycle.
REQ-020 On a tick with row_pos>0, row_pos SHALL decrement by 1.
REQ-021 On a tick with row_pos==0, landed SHALL pulse for one cycle and the piece SHALL respawn at (ROWS-1, SPAWN_COL) on the same edge.
REQ-022 If a tick and an accepted move request coincide, the tick SHALL win and the move request SHALL be discarded, no bump.
REQ-023 cells SHALL be exactly one-hot at all times, registered, consistent with row_pos/col_pos on the same cycle.
REQ-024 Position SHALL be a 3-state-free register pair; no state machine beyond debouncer states IDLE_LO, CHECK, IDLE_HI per button.

Reset
REQ-025 rst high SHALL immediately force row_pos=ROWS-1, col_pos=SPAWN_COL, matching cells, bump=0, landed=0, gravity counter=0, synchronisers and debounced levels=0, debounce counters=0.
REQ-026 A button held through reset release SHALL generate one move request after the debounce interval.
REQ-027 Reset asserted mid-debounce or mid-gravity-count SHALL discard partial progress.

Configuration
REQ-028 Macro GRID_GRAVITY_EN defined: gravity counter, REQ-019..REQ-022 and landed behaviour compiled in.
REQ-029 GRID_GRAVITY_EN undefined: no gravity counter, landed tied 0, position changes only by button, DROP_DIV unused.

Structure
REQ-030 Package grid_pkg SHALL hold button index constants (BTN_LEFT=0, BTN_DOWN=1, BTN_UP=2, BTN_RIGHT=3) and the debouncer state enum.
REQ-031 Sub-module btn_debounce (synchroniser, debouncer, rising-edge pulse) SHALL be instantiated four times.

Verification (COLS=4, ROWS=3, SPAWN_COL=0, DEB_CYCLES=4, DROP_DIV=64)
REQ-032 Reset release, press button[3] stable 20 cycles -> col_pos 0->1 exactly 7 edges after first sample, cells=12'h200, bump=0.
REQ-033 From col 3 press button[3] -> col_pos stays 3, bump one cycle; from row 2 press button[2] -> bump, no wrap.
REQ-034 Press button[0] with 2-cycle glitches shorter than DEB_CYCLES -> no move; buttons [0]+[3] released together -> ignored.
REQ-035 Idle from reset -> row_pos 2->1->0 at ticks 64,128; tick at 192 -> landed pulse, position (2,0), cells=12'h100.
REQ-036 Accepted move coinciding with tick -> only gravity applied; rst asserted mid-debounce -> outputs at reset values immediately, no later move.
